pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub.sv | 146 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Pipelined adder/subtractor with optional saturation. The carry chain is cut
//   into STAGES register slices of CW = ceil(N/STAGES) bits each. Every slice
//   register carries the whole transaction: the operands, the partial sum built
//   so far, the carry into the next slice and the mode bits. Each stage only
//   fills in its own bit range of the sum. The last slice also decides overflow
//   and saturation, then loads the output register.
//
// Handshake (valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer keeps its payload stable while valid && !ready.
//   stall = out_valid && !out_ready, and in_ready = !stall (combinational).
//   A stall freezes every stage, data and valid bits alike. Otherwise all
//   stages advance, and empty slots move down the pipe as valid = 0.
//
// Ports
//   clk, rst_n           clock; synchronous active-low reset
//   in_valid / in_ready  input handshake
//   A, B, op             operands; op = 0 gives A+B, op = 1 gives A-B
//   signed_mode          1 = two's-complement overflow rules, 0 = unsigned
//   sat_en               clamp Result on overflow
//   out_valid/out_ready  output handshake
//   Result               sum or difference, saturated when enabled
//   CarryOut, Overflow   raw flags of the unsaturated operation
//   cnt_clear            synchronous clear of ovf_count, wins over increment
//   ovf_count            saturating count of consumed results with Overflow = 1
module pipelined_addsub #(
  parameter int N      = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             op,
  input  logic             signed_mode,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     Result,
  output logic             CarryOut,
  output logic             Overflow,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int CW = (N + STAGES - 1) / STAGES;

  // One pipeline slot.
  // In stage STAGES-1, s holds the final (possibly saturated) Result and c
  // holds CarryOut.
  typedef struct packed {
    logic         v;
    logic [N-1:0] a;
    logic [N-1:0] bm;   // B, already inverted for subtraction
    logic [N-1:0] s;    // sum bits produced so far
    logic         c;    // carry into the next slice
    logic         op;
    logic         sm;
    logic         sat;
    logic         ovf;
  } stage_t;

  stage_t st_q [STAGES];
  stage_t st_d [STAGES];
  logic   stall;
  logic   adv;

  assign stall    = st_q[STAGES-1].v && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  always_comb begin
    stage_t cur;
    stage_t nxt;
    logic   c;
    logic   sgn_ovf;
    logic   ovf;
    // Stage 0 takes its slot from the input ports. The +1 needed for
    // subtraction enters as the carry into bit 0.
    cur     = '0;
    cur.v   = in_valid;
    cur.a   = A;
    cur.bm  = op ? ~B : B;
    cur.c   = op;
    cur.op  = op;
    cur.sm  = signed_mode;
    cur.sat = sat_en;
    for (int k = 0; k < STAGES; k++) begin
      nxt = cur;
      c   = cur.c;
      for (int i = 0; i < N; i++) begin
        if (i >= k * CW && i < (k + 1) * CW) begin
          nxt.s[i] = cur.a[i] ^ cur.bm[i] ^ c;
          c        = (cur.a[i] & cur.bm[i]) | (c & (cur.a[i] ^ cur.bm[i]));
        end
      end
      nxt.c = c;
      if (k == STAGES - 1) begin
        sgn_ovf = (cur.a[N-1] == cur.bm[N-1]) && (nxt.s[N-1] != cur.a[N-1]);
        // Unsigned: a carry out on add, or a borrow (no carry) on sub.
        ovf     = cur.sm ? sgn_ovf : (cur.op ? ~c : c);
        nxt.ovf = ovf;
        if (cur.sat && ovf) begin
          if (cur.sm)
            nxt.s = cur.a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          else
            nxt.s = cur.op ? '0 : '1;
        end
      end
      st_d[k] = nxt;
      cur     = st_q[k];
    end
  end

  // An empty slot only clears its valid bit, so idle input values never
  // reach the payload registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        if (st_d[k].v) st_q[k]   <= st_d[k];
        else           st_q[k].v <= 1'b0;
      end
    end
  end

  assign out_valid = st_q[STAGES-1].v;
  assign Result    = st_q[STAGES-1].s;
  assign CarryOut  = st_q[STAGES-1].c;
  assign Overflow  = st_q[STAGES-1].ovf;

  always_ff @(posedge clk) begin
    if (!rst_n)
      ovf_count <= '0;
    else if (cnt_clear)
      ovf_count <= '0;
    else if (out_valid && out_ready && Overflow && (ovf_count != '1))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub.
//   Instance 0 is N=8, STAGES=2, CNT_W=4. The other six instances cover
//   N=8 and N=13 with STAGES = 1, 3 and 8. All instances share one stimulus
//   bus, and each one has its own expected queue and latency bookkeeping.
module tb_pipelined_addsub;
  localparam int NI = 7;

  function automatic int n_of(int i);
    return (i < 4) ? 8 : 13;
  endfunction
  function automatic int s_of(int i);
    case (i)
      0: return 2;
      1, 4: return 1;
      2, 5: return 3;
      default: return 8;
    endcase
  endfunction
  function automatic int c_of(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic op = 1'b0;
  logic signed_mode = 1'b0;
  logic sat_en = 1'b0;
  logic out_ready = 1'b1;
  logic cnt_clear = 1'b0;
  logic [12:0] a_in = '0;
  logic [12:0] b_in = '0;

  logic [NI-1:0]       ir_w, ov_w, co_w, of_w;
  logic [NI-1:0][12:0] res_w;
  logic [NI-1:0][7:0]  cnt_w;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int GN = n_of(gi);
    localparam int GS = s_of(gi);
    localparam int GC = c_of(gi);
    logic [GN-1:0] res;
    logic [GC-1:0] cnt;
    logic ir, ov, co, ovf;
    pipelined_addsub #(.N(GN), .STAGES(GS), .CNT_W(GC)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir),
      .A(a_in[GN-1:0]), .B(b_in[GN-1:0]), .op(op), .signed_mode(signed_mode),
      .sat_en(sat_en), .out_valid(ov), .out_ready(out_ready), .Result(res),
      .CarryOut(co), .Overflow(ovf), .cnt_clear(cnt_clear), .ovf_count(cnt)
    );
    assign ir_w[gi]  = ir;
    assign ov_w[gi]  = ov;
    assign co_w[gi]  = co;
    assign of_w[gi]  = ovf;
    assign res_w[gi] = 13'(res);
    assign cnt_w[gi] = 8'(cnt);
  end

  // Scoreboard state
  logic [14:0] exp_q [NI][$];   // {Result, CarryOut, Overflow}
  int          acc_q [NI][$];   // cycle in which the transaction was accepted
  int          stl_q [NI][$];   // stall count at acceptance
  int          cnt_m [NI];
  int          stall_cnt [NI];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void chk(string name, int act, int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [14:0] model(int n, logic [12:0] a, logic [12:0] b,
                                        logic o, logic s, logic t);
    int mask, ua, ub, sa, sb, r, sum, smax, smin, satv;
    logic co, ov;
    mask = (1 << n) - 1;
    ua   = int'(a) & mask;
    ub   = int'(b) & mask;
    if (!o) begin
      co  = (ua + ub) > mask;
      sum = (ua + ub) & mask;
    end else begin
      co  = ua >= ub;
      sum = (ua - ub) & mask;
    end
    sa   = (ua >= (1 << (n - 1))) ? ua - (1 << n) : ua;
    sb   = (ub >= (1 << (n - 1))) ? ub - (1 << n) : ub;
    r    = o ? sa - sb : sa + sb;
    smax = (1 << (n - 1)) - 1;
    smin = -(1 << (n - 1));
    if (s) begin
      ov   = (r > smax) || (r < smin);
      satv = (r > smax) ? smax : (smin & mask);
    end else begin
      ov   = o ? !co : co;
      satv = o ? 0 : mask;
    end
    return {13'((t && ov) ? satv : sum), co, ov};
  endfunction

  // Compare process: runs once per cycle, half a cycle before the active edge.
  always @(negedge clk) begin
    logic        stall_now;
    logic [14:0] h;
    int          mx;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        exp_q[i].delete();
        acc_q[i].delete();
        stl_q[i].delete();
        cnt_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        stall_now = ov_w[i] && !out_ready;
        chk($sformatf("in_ready[%0d]", i), int'(ir_w[i]), int'(!stall_now));
        chk($sformatf("ovf_count[%0d]", i), int'(cnt_w[i]), cnt_m[i]);
        if (ov_w[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("stale_out_valid[%0d]", i), 1, 0);
          end else begin
            h = exp_q[i][0];
            chk($sformatf("result[%0d]", i), int'(res_w[i]), int'(h[14:2]));
            chk($sformatf("carry_out[%0d]", i), int'(co_w[i]), int'(h[1]));
            chk($sformatf("overflow[%0d]", i), int'(of_w[i]), int'(h[0]));
            if (out_ready) begin
              chk($sformatf("latency[%0d]", i), cyc - acc_q[i][0],
                  s_of(i) + stall_cnt[i] - stl_q[i][0]);
              void'(exp_q[i].pop_front());
              void'(acc_q[i].pop_front());
              void'(stl_q[i].pop_front());
              mx = (1 << c_of(i)) - 1;
              if (h[0] && cnt_m[i] < mx) cnt_m[i]++;
            end
          end
        end
        if (cnt_clear) cnt_m[i] = 0;
        if (in_valid && ir_w[i]) begin
          exp_q[i].push_back(model(n_of(i), a_in, b_in, op, signed_mode, sat_en));
          acc_q[i].push_back(cyc);
          stl_q[i].push_back(stall_cnt[i]);
        end
        if (stall_now) stall_cnt[i]++;
      end
    end
    cyc++;
  end

  // Driver tasks. Inputs change 1 ns after the active edge.
  task automatic send(input logic [12:0] a, input logic [12:0] b,
                      input logic o, input logic s, input logic t);
    logic acc;
    int   w;
    in_valid = 1'b1; a_in = a; b_in = b; op = o; signed_mode = s; sat_en = t;
    w = 0;
    forever begin
      @(negedge clk);
      acc = ir_w[0];
      @(posedge clk);
      #1;
      if (acc) break;
      w++;
      if (w > 200) begin
        chk("send_timeout", w, 0);
        break;
      end
    end
    in_valid = 1'b0;
    a_in = 13'($urandom); b_in = 13'($urandom);
    op = 1'($urandom); signed_mode = 1'($urandom); sat_en = 1'($urandom);
  endtask

  task automatic send_rand();
    send(13'($urandom), 13'($urandom), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic bp_on;

  initial begin
    // Pin the reference model with hand-computed results.
    chk("pin_sadd_sat",  int'(model(8, 13'h70, 13'h20, 1'b0, 1'b1, 1'b1)), int'({13'h7F, 1'b0, 1'b1}));
    chk("pin_ssub_wrap", int'(model(8, 13'h80, 13'h01, 1'b1, 1'b1, 1'b0)), int'({13'h7F, 1'b1, 1'b1}));
    chk("pin_ssub_sat",  int'(model(8, 13'h80, 13'h01, 1'b1, 1'b1, 1'b1)), int'({13'h80, 1'b1, 1'b1}));
    chk("pin_uadd_sat",  int'(model(8, 13'hF0, 13'h20, 1'b0, 1'b0, 1'b1)), int'({13'hFF, 1'b1, 1'b1}));
    chk("pin_usub_sat",  int'(model(8, 13'h05, 13'h09, 1'b1, 1'b0, 1'b1)), int'({13'h00, 1'b0, 1'b1}));

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_during_reset", int'(ir_w[0]), 1);
    chk("out_valid_during_reset", int'(ov_w), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cnt_after_reset", int'(cnt_w[0]), 0);
    @(posedge clk);
    #1;

    // First transaction: exact latency and literal outputs
    send(13'h70, 13'h20, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("out_valid_not_early", int'(ov_w[0]), 0);
    @(negedge clk);
    chk("first_out_valid", int'(ov_w[0]), 1);
    chk("first_result", int'(res_w[0]), 'h7F);
    chk("first_overflow", int'(of_w[0]), 1);
    chk("first_carry", int'(co_w[0]), 0);
    @(posedge clk);
    #1;
    idle(10);
    chk("cnt_after_first", int'(cnt_w[0]), 1);

    // Remaining directed vectors, sent back to back
    send(13'h80, 13'h01, 1'b1, 1'b1, 1'b0);
    send(13'h80, 13'h01, 1'b1, 1'b1, 1'b1);
    send(13'hF0, 13'h20, 1'b0, 1'b0, 1'b1);
    send(13'h05, 13'h09, 1'b1, 1'b0, 1'b1);
    idle(12);
    chk("cnt_after_directed", int'(cnt_w[0]), 5);

    // Backpressure: 6 back-to-back transactions, out_ready low for 3 cycles
    fork
      begin
        for (int k = 0; k < 6; k++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(12);

    // Random stream at full throughput with occasional gaps
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send_rand();
    end
    idle(12);

    // Counter saturation: 17 overflowing results
    cnt_clear = 1'b1;
    @(posedge clk);
    #1 cnt_clear = 1'b0;
    for (int k = 0; k < 17; k++) send(13'h1FFF, 13'h0001, 1'b0, 1'b0, 1'b1);
    idle(12);
    chk("cnt_saturated", int'(cnt_w[0]), 'hF);

    // A clear in the same cycle as an overflowing handshake
    out_ready = 1'b0;
    send(13'h1FFF, 13'h0001, 1'b0, 1'b0, 1'b1);
    idle(12);
    chk("cnt_before_clear", int'(cnt_w[0]), 'hF);
    out_ready = 1'b1;
    cnt_clear = 1'b1;
    @(posedge clk);
    #1 cnt_clear = 1'b0;
    @(negedge clk);
    chk("cnt_clear_wins", int'(cnt_w[0]), 0);
    @(posedge clk);
    #1;
    idle(4);

    // Reset with two transactions in flight
    send_rand();
    send_rand();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("out_valid_after_reset", int'(ov_w[0]), 0);
    @(posedge clk);
    #1;
    idle(12);

    // Random stream with random backpressure and occasional counter clears
    bp_on = 1'b1;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 4) == 0) idle(1);
          send_rand();
        end
        bp_on = 1'b0;
      end
      begin
        while (bp_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
          cnt_clear = ($urandom_range(0, 15) == 0);
        end
      end
    join
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    idle(20);

    // Nothing may be left outstanding
    @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("queue_drained[%0d]", i), exp_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
